cache: RTL and testbench
========================

CACHE -- requirements
Module: cache

Interface
REQ-001 SHALL have parameter LINE_IX_BITWIDTH, default 1: cache holds 2^LINE_IX_BITWIDTH lines.
REQ-002 SHALL have parameter RAM_DEPTH_BITWIDTH, default 10: width of br_addr.
REQ-003 SHALL have parameter RAM_ADDRESSING_MODE, default 3: br_addr unit is 2^mode bytes (0 byte, 1 half, 2 word, 3 64-bit).
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 enable  input  1  access request valid.
REQ-007 address  input  32  byte address, bits[1:0] ignored (word-aligned).
REQ-008 data_in  input  32  write data, byte lanes already positioned.
REQ-009 write_enable  input  4  per-byte write strobe; 0 = read.
REQ-010 data_out  output  32  word at address.
REQ-011 data_out_ready  output  1  data_out valid.
REQ-012 busy  output  1  access stalled; requester holds inputs stable.
REQ-013 br_cmd  output  1  0 read, 1 write.
REQ-014 br_cmd_en  output  1  one-cycle command strobe.
REQ-015 br_addr  output  RAM_DEPTH_BITWIDTH  burst RAM address.
REQ-016 br_wr_data  output  64  write beat.
REQ-017 br_data_mask  output  8  constant 0 (all bytes written).
REQ-018 br_rd_data  input  64  read beat.
REQ-019 br_rd_data_valid  input  1  br_rd_data valid this cycle.

Function
REQ-020 SHALL be direct-mapped write-back: line 32 bytes (8 words, 4 beats of 64 bits); column = address[4:2]; line index = address[LINE_IX_BITWIDTH+4:5]; tag = address[31:LINE_IX_BITWIDTH+5]; per line: tag, valid, dirty.
REQ-021 hit SHALL be enable && valid[index] && tag match, evaluated combinationally in state IDLE.
REQ-022 data_out SHALL combinationally show stored word at column of indexed line, regardless of hit.
REQ-023 data_out_ready SHALL be enable && hit && write_enable==0 (same cycle, zero latency).
REQ-024 busy SHALL be 1 when state != IDLE, or in IDLE when enable && !hit; otherwise 0.
REQ-025 write hit: at clock edge, bytes with write_enable[i]=1 SHALL be updated from data_in[8i+7:8i], dirty set; busy stays 0.
REQ-026 States IDLE, WB (write-back), RD_CMD, RD_WAIT; IDLE + enable + miss -> WB if line valid && dirty, else RD_CMD.
REQ-027 WB: 4 consecutive cycles, br_cmd=1, br_cmd_en=1 only on first, br_addr = old line byte address ({tag,index,5'b0}) >> RAM_ADDRESSING_MODE, br_wr_data beat k = {word 2k+1, word 2k}; then -> RD_CMD.
REQ-028 RD_CMD: one cycle br_cmd=0, br_cmd_en=1, br_addr = new line byte address >> RAM_ADDRESSING_MODE; -> RD_WAIT.
REQ-029 RD_WAIT: each cycle with br_rd_data_valid stores beat k (k=0..3) into words 2k (low half), 2k+1 (high half); after 4th beat set tag, valid=1, dirty=0, -> IDLE.
REQ-030 After fill the pending access SHALL re-evaluate as hit in IDLE (read ready or write applied next cycle).
REQ-031 br_addr SHALL be truncated to RAM_DEPTH_BITWIDTH bits; br_cmd_en=0 outside issue cycles; br_wr_data undefined-but-stable (hold 0) outside WB.
REQ-032 Changes of enable/address during non-IDLE states SHALL be ignored until IDLE; enable=0 in IDLE SHALL cause no state change or write.

Reset
REQ-033 rst_n low SHALL immediately: state IDLE, all valid and dirty bits 0, br_cmd=0, br_cmd_en=0, br_addr=0, br_wr_data=0; data arrays need not be cleared.
REQ-034 Reset mid-burst SHALL abort the burst; dirty contents are discarded.

Verification
REQ-035 After reset, read 0x0000_0004 -> busy=1, br_cmd_en pulse br_cmd=0 br_addr=0; 4 beats beat0=0x11111111_22222222 -> data_out=0x11111111, data_out_ready=1.
REQ-036 Write 0xAABBCCDD we=4'b0010 at 0x0000_0000 after fill -> busy=0; readback word0 = 0x2222CC22.
REQ-037 Access 0x0000_0040 (same index, LINE_IX=1, other tag) with dirty line -> 4 write beats br_cmd=1 br_addr=0, beat0=0x11111111_2222CC22, then read cmd br_addr=8.
REQ-038 Clean miss -> no write-back, read cmd directly.
REQ-039 Read 0x0000_0020 (index 1) then 0x0000_0000 -> both hit with no br_cmd_en after fills.
REQ-040 Assert rst_n low during WB beat 2 -> br_cmd_en=0, busy recomputed from IDLE, all lines invalid (next read misses).

Source files
------------

// File: rtl/cache.sv
// -----------------------------------------------------------------------------
// cache -- direct-mapped, write-back, write-allocate cache in front of a
// 64-bit burst RAM.
//
// Line = 32 bytes = 8 words = 4 beats of 64 bits.
//   column     = address[4:2]
//   line index = address[LINE_IX_BITWIDTH+4:5]
//   tag        = address[31:LINE_IX_BITWIDTH+5]
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   enable            access request valid
//   address           byte address (bits [1:0] ignored)
//   data_in           write data, byte lanes already positioned
//   write_enable      per-byte write strobe, 0 = read
//   data_out          word at address in the indexed line (always shown)
//   data_out_ready    read hit this cycle
//   busy              access stalled; requester holds its inputs
//   br_cmd            burst RAM command: 0 read, 1 write
//   br_cmd_en         one-cycle command strobe
//   br_addr           burst RAM address (line byte address >> addressing mode)
//   br_wr_data        write-back beat
//   br_data_mask      always 0 (every byte written)
//   br_rd_data        read beat from burst RAM
//   br_rd_data_valid  br_rd_data valid this cycle
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | serve hits combinationally; a miss latches the request
// S_WB      | 4 cycles streaming the dirty victim line out
// S_RD_CMD  | one cycle issuing the line-fill read command
// S_RD_WAIT | collect 4 read beats, then mark line valid and clean
// -----------------------------------------------------------------------------
module cache #(
    parameter int LINE_IX_BITWIDTH    = 1,
    parameter int RAM_DEPTH_BITWIDTH  = 10,
    parameter int RAM_ADDRESSING_MODE = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic [31:0]                   address,
    input  logic [31:0]                   data_in,
    input  logic [3:0]                    write_enable,
    output logic [31:0]                   data_out,
    output logic                          data_out_ready,
    output logic                          busy,
    output logic                          br_cmd,
    output logic                          br_cmd_en,
    output logic [RAM_DEPTH_BITWIDTH-1:0] br_addr,
    output logic [63:0]                   br_wr_data,
    output logic [7:0]                    br_data_mask,
    input  logic [63:0]                   br_rd_data,
    input  logic                          br_rd_data_valid
);

    localparam int NUM_LINES = 1 << LINE_IX_BITWIDTH;
    localparam int TAG_W     = 27 - LINE_IX_BITWIDTH;
    localparam int WIX_W     = LINE_IX_BITWIDTH + 3;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WB      = 2'd1,
        S_RD_CMD  = 2'd2,
        S_RD_WAIT = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [TAG_W-1:0]     tag_q [NUM_LINES];
    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [31:0]          mem_q [NUM_LINES*8];

    // Line address of the request that missed; held for the whole refill.
    logic [31:5] pend_addr_q;
    // Beat down-counter: 3 on the first beat of a burst, 0 on the last.
    logic [1:0]  beat_cnt_q;

    logic [LINE_IX_BITWIDTH-1:0] req_idx;
    logic [TAG_W-1:0]            req_tag;
    logic [2:0]                  req_col;
    logic [LINE_IX_BITWIDTH-1:0] pend_idx;
    logic [TAG_W-1:0]            pend_tag;
    logic [1:0]                  beat_k;
    logic                        hit;
    logic                        write_hit;
    logic                        miss;
    logic [31:0]                 line_byte_addr;
    logic [31:0]                 line_ram_addr;

    assign req_idx  = address[LINE_IX_BITWIDTH+4:5];
    assign req_tag  = address[31:LINE_IX_BITWIDTH+5];
    assign req_col  = address[4:2];
    assign pend_idx = pend_addr_q[LINE_IX_BITWIDTH+4:5];
    assign pend_tag = pend_addr_q[31:LINE_IX_BITWIDTH+5];
    assign beat_k   = 2'd3 - beat_cnt_q;

    assign hit       = (state_q == S_IDLE) && enable && valid_q[req_idx]
                       && (tag_q[req_idx] == req_tag);
    assign write_hit = hit && (write_enable != 4'b0000);
    assign miss      = (state_q == S_IDLE) && enable && !hit;

    assign data_out       = mem_q[{req_idx, req_col}];
    assign data_out_ready = hit && (write_enable == 4'b0000);
    assign busy           = (state_q != S_IDLE) || miss;
    assign br_data_mask   = 8'h00;

    // Outputs derive from state only, so reset forcing IDLE clears them at once.
    assign line_ram_addr = line_byte_addr >> RAM_ADDRESSING_MODE;
    assign br_addr       = line_ram_addr[RAM_DEPTH_BITWIDTH-1:0];

    always_comb begin
        state_d        = state_q;
        br_cmd         = 1'b0;
        br_cmd_en      = 1'b0;
        br_wr_data     = 64'h0;
        line_byte_addr = 32'h0;
        case (state_q)
            S_IDLE: begin
                if (miss) begin
                    if (valid_q[req_idx] && dirty_q[req_idx]) state_d = S_WB;
                    else                                      state_d = S_RD_CMD;
                end
            end
            S_WB: begin
                br_cmd         = 1'b1;
                br_cmd_en      = (beat_cnt_q == 2'd3);
                line_byte_addr = {tag_q[pend_idx], pend_idx, 5'b00000};
                br_wr_data     = {mem_q[{pend_idx, beat_k, 1'b1}],
                                  mem_q[{pend_idx, beat_k, 1'b0}]};
                if (beat_cnt_q == 2'd0) state_d = S_RD_CMD;
            end
            S_RD_CMD: begin
                br_cmd_en      = 1'b1;
                line_byte_addr = {pend_addr_q, 5'b00000};
                state_d        = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (br_rd_data_valid && (beat_cnt_q == 2'd0)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            valid_q     <= '0;
            dirty_q     <= '0;
            pend_addr_q <= '0;
            beat_cnt_q  <= 2'd3;
            for (int i = 0; i < NUM_LINES; i++) tag_q[i] <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    beat_cnt_q <= 2'd3;
                    if (miss)      pend_addr_q      <= address[31:5];
                    if (write_hit) dirty_q[req_idx] <= 1'b1;
                end
                S_WB: begin
                    beat_cnt_q <= beat_cnt_q - 2'd1;
                end
                S_RD_CMD: begin
                    beat_cnt_q <= 2'd3;
                end
                S_RD_WAIT: begin
                    if (br_rd_data_valid) begin
                        beat_cnt_q <= beat_cnt_q - 2'd1;
                        if (beat_cnt_q == 2'd0) begin
                            tag_q[pend_idx]   <= pend_tag;
                            valid_q[pend_idx] <= 1'b1;
                            dirty_q[pend_idx] <= 1'b0;
                        end
                    end
                end
                default: beat_cnt_q <= 2'd3;
            endcase
        end
    end

    // Data array is not reset; valid bits guard it.
    always_ff @(posedge clk) begin
        if (write_hit) begin
            for (int i = 0; i < 4; i++) begin
                if (write_enable[i])
                    mem_q[{req_idx, req_col}][8*i +: 8] <= data_in[8*i +: 8];
            end
        end
        if ((state_q == S_RD_WAIT) && br_rd_data_valid) begin
            mem_q[{pend_idx, beat_k, 1'b0}] <= br_rd_data[31:0];
            mem_q[{pend_idx, beat_k, 1'b1}] <= br_rd_data[63:32];
        end
    end

endmodule

// File: tb/tb_cache.sv
module tb_cache;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [31:0] address;
    logic [31:0] data_in;
    logic [3:0]  write_enable;
    logic [31:0] data_out;
    logic        data_out_ready;
    logic        busy;
    logic        br_cmd;
    logic        br_cmd_en;
    logic [9:0]  br_addr;
    logic [63:0] br_wr_data;
    logic [7:0]  br_data_mask;
    logic [63:0] br_rd_data;
    logic        br_rd_data_valid;

    int asserts  = 0;
    int failures = 0;

    cache dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .enable           (enable),
        .address          (address),
        .data_in          (data_in),
        .write_enable     (write_enable),
        .data_out         (data_out),
        .data_out_ready   (data_out_ready),
        .busy             (busy),
        .br_cmd           (br_cmd),
        .br_cmd_en        (br_cmd_en),
        .br_addr          (br_addr),
        .br_wr_data       (br_wr_data),
        .br_data_mask     (br_data_mask),
        .br_rd_data       (br_rd_data),
        .br_rd_data_valid (br_rd_data_valid)
    );

    always #5 clk = ~clk;

    // Bounded wait for the next command strobe; returns at negedge+1 of that cycle.
    task automatic wait_cmd(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk); #1;
            if (br_cmd_en === 1'b1) seen = 1'b1;
        end
        asserts++;
        if (!seen) begin failures++; $display("FAIL %s cmd_wait: no br_cmd_en within 12 cycles", name); end
    endtask

    // Expects a read command this cycle, then supplies four beats.
    task automatic do_fill(input string name, input logic [9:0] exp_addr,
                           input logic [63:0] b0, input logic [63:0] b1,
                           input logic [63:0] b2, input logic [63:0] b3);
        logic [63:0] beats [4];
        beats = '{b0, b1, b2, b3};
        asserts++; if (br_cmd !== 1'b0) begin failures++; $display("FAIL %s rd_cmd: got %b want 0", name, br_cmd); end
        asserts++; if (br_addr !== exp_addr) begin failures++; $display("FAIL %s rd_addr: got %0d want %0d", name, br_addr, exp_addr); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            br_rd_data_valid = 1'b1;
            br_rd_data       = beats[k];
            #1;
            asserts++; if (br_cmd_en !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL %s rd_wait beat%0d: cmd_en=%b busy=%b want 0/1", name, k, br_cmd_en, busy); end
        end
        @(negedge clk);
        br_rd_data_valid = 1'b0;
        br_rd_data       = 64'h0;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; address = 32'h0; data_in = 32'h0;
        write_enable = 4'b0000; br_rd_data = 64'h0; br_rd_data_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        asserts++; if (busy !== 1'b0) begin failures++; $display("FAIL reset busy: got %b want 0", busy); end
        asserts++; if (br_cmd_en !== 1'b0 || br_cmd !== 1'b0) begin failures++; $display("FAIL reset cmd: got en=%b cmd=%b want 0/0", br_cmd_en, br_cmd); end
        asserts++; if (br_addr !== 10'd0) begin failures++; $display("FAIL reset br_addr: got %0d want 0", br_addr); end
        asserts++; if (br_wr_data !== 64'h0) begin failures++; $display("FAIL reset br_wr_data: got %h want 0", br_wr_data); end
        asserts++; if (br_data_mask !== 8'h00) begin failures++; $display("FAIL reset mask: got %h want 00", br_data_mask); end
        asserts++; if (data_out_ready !== 1'b0) begin failures++; $display("FAIL reset ready: got %b want 0", data_out_ready); end
        enable = 1'b1; address = 32'h4; #1;
        asserts++; if (busy !== 1'b1) begin failures++; $display("FAIL reset miss_busy: got %b want 1", busy); end
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_read_miss();
        @(negedge clk);
        enable = 1'b1; address = 32'h0000_0004; write_enable = 4'b0000; #1;
        asserts++; if (busy !== 1'b1 || data_out_ready !== 1'b0) begin failures++; $display("FAIL read_miss start: busy=%b ready=%b want 1/0", busy, data_out_ready); end
        wait_cmd("read_miss");
        do_fill("read_miss", 10'd0, 64'h11111111_22222222, 64'h33333333_44444444,
                64'h55555555_66666666, 64'h77777777_88888888);
        asserts++; if (data_out !== 32'h11111111) begin failures++; $display("FAIL read_miss data: got %h want 11111111", data_out); end
        asserts++; if (data_out_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL read_miss hit: ready=%b busy=%b want 1/0", data_out_ready, busy); end
        address = 32'h0000_001C; #1;
        asserts++; if (data_out !== 32'h77777777) begin failures++; $display("FAIL read_miss word7: got %h want 77777777", data_out); end
    endtask

    task automatic test_write_hit();
        @(negedge clk);
        address = 32'h0; data_in = 32'hAABBCCDD; write_enable = 4'b0010; #1;
        asserts++; if (busy !== 1'b0 || data_out_ready !== 1'b0 || br_cmd_en !== 1'b0) begin failures++; $display("FAIL write_hit stall: busy=%b ready=%b cmd_en=%b want 0/0/0", busy, data_out_ready, br_cmd_en); end
        @(negedge clk);
        write_enable = 4'b0000; data_in = 32'h0; #1;
        asserts++; if (data_out !== 32'h2222CC22) begin failures++; $display("FAIL write_hit word0: got %h want 2222cc22", data_out); end
        asserts++; if (data_out_ready !== 1'b1) begin failures++; $display("FAIL write_hit ready: got %b want 1", data_out_ready); end
        address = 32'h4; #1;
        asserts++; if (data_out !== 32'h11111111) begin failures++; $display("FAIL write_hit word1: got %h want 11111111", data_out); end
    endtask

    task automatic test_clean_miss();
        @(negedge clk);
        address = 32'h0000_0020; #1;
        asserts++; if (busy !== 1'b1) begin failures++; $display("FAIL clean_miss busy: got %b want 1", busy); end
        wait_cmd("clean_miss");
        do_fill("clean_miss", 10'd4, 64'hBBBB0001_BBBB0000, 64'hBBBB0003_BBBB0002,
                64'hBBBB0005_BBBB0004, 64'hBBBB0007_BBBB0006);
        asserts++; if (data_out !== 32'hBBBB0000 || data_out_ready !== 1'b1) begin failures++; $display("FAIL clean_miss data: got %h/%b want bbbb0000/1", data_out, data_out_ready); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [4];
        logic [31:0] exps  [4];
        addrs = '{32'h20, 32'h00, 32'h24, 32'h00};
        exps  = '{32'hBBBB0000, 32'h2222CC22, 32'hBBBB0001, 32'h2222CC22};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            address = addrs[i]; #1;
            asserts++; if (busy !== 1'b0 || br_cmd_en !== 1'b0 || data_out_ready !== 1'b1) begin failures++; $display("FAIL back_to_back[%0d] ctl: busy=%b cmd_en=%b ready=%b want 0/0/1", i, busy, br_cmd_en, data_out_ready); end
            asserts++; if (data_out !== exps[i]) begin failures++; $display("FAIL back_to_back[%0d] data: got %h want %h", i, data_out, exps[i]); end
        end
    endtask

    task automatic test_dirty_evict();
        logic [63:0] wb [4];
        wb = '{64'h11111111_2222CC22, 64'h33333333_44444444,
               64'h55555555_66666666, 64'h77777777_88888888};
        @(negedge clk);
        address = 32'h0000_0040; #1;
        asserts++; if (busy !== 1'b1) begin failures++; $display("FAIL evict busy: got %b want 1", busy); end
        wait_cmd("evict_wb");
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                @(negedge clk);
                if (k == 1) begin address = 32'h0000_0080; enable = 1'b0; end
                if (k == 3) begin address = 32'h0000_0040; enable = 1'b1; end
                #1;
            end
            asserts++; if (br_cmd !== 1'b1 || br_cmd_en !== (k == 0)) begin failures++; $display("FAIL evict beat%0d cmd: cmd=%b en=%b want 1/%0d", k, br_cmd, br_cmd_en, (k == 0)); end
            asserts++; if (br_addr !== 10'd0) begin failures++; $display("FAIL evict beat%0d addr: got %0d want 0", k, br_addr); end
            asserts++; if (br_wr_data !== wb[k]) begin failures++; $display("FAIL evict beat%0d data: got %h want %h", k, br_wr_data, wb[k]); end
        end
        wait_cmd("evict_rd");
        do_fill("evict", 10'd8, 64'hCCCC0001_CCCC0000, 64'hCCCC0003_CCCC0002,
                64'hCCCC0005_CCCC0004, 64'hCCCC0007_CCCC0006);
        asserts++; if (data_out !== 32'hCCCC0000 || data_out_ready !== 1'b1) begin failures++; $display("FAIL evict data: got %h/%b want cccc0000/1", data_out, data_out_ready); end
    endtask

    task automatic test_clean_valid_miss();
        @(negedge clk);
        address = 32'h0000_0060; #1;
        asserts++; if (busy !== 1'b1) begin failures++; $display("FAIL clean_valid busy: got %b want 1", busy); end
        wait_cmd("clean_valid");
        do_fill("clean_valid", 10'd12, 64'hDDDD0001_DDDD0000, 64'hDDDD0003_DDDD0002,
                64'hDDDD0005_DDDD0004, 64'hDDDD0007_DDDD0006);
        address = 32'h0000_007C; #1;
        asserts++; if (data_out !== 32'hDDDD0007 || data_out_ready !== 1'b1) begin failures++; $display("FAIL clean_valid data: got %h/%b want dddd0007/1", data_out, data_out_ready); end
    endtask

    task automatic test_reset_mid_wb();
        @(negedge clk);
        address = 32'h0000_0040; data_in = 32'h12345678; write_enable = 4'b1111; #1;
        asserts++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_wb dirty_busy: got %b want 0", busy); end
        @(negedge clk);
        write_enable = 4'b0000; address = 32'h0; #1;
        wait_cmd("rst_wb");
        asserts++; if (br_cmd !== 1'b1 || br_addr !== 10'd8) begin failures++; $display("FAIL rst_wb beat0: cmd=%b addr=%0d want 1/8", br_cmd, br_addr); end
        asserts++; if (br_wr_data !== 64'hCCCC0001_12345678) begin failures++; $display("FAIL rst_wb beat0 data: got %h want cccc000112345678", br_wr_data); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0; #1;
        asserts++; if (br_cmd_en !== 1'b0 || br_cmd !== 1'b0) begin failures++; $display("FAIL rst_wb cmd: en=%b cmd=%b want 0/0", br_cmd_en, br_cmd); end
        asserts++; if (br_addr !== 10'd0 || br_wr_data !== 64'h0) begin failures++; $display("FAIL rst_wb bus: addr=%0d data=%h want 0/0", br_addr, br_wr_data); end
        asserts++; if (busy !== 1'b1) begin failures++; $display("FAIL rst_wb busy: got %b want 1", busy); end
        @(negedge clk);
        rst_n = 1'b1; #1;
        wait_cmd("rst_wb_refill");
        do_fill("rst_wb_refill", 10'd0, 64'hEEEE0001_EEEE0000, 64'hEEEE0003_EEEE0002,
                64'hEEEE0005_EEEE0004, 64'hEEEE0007_EEEE0006);
        asserts++; if (data_out !== 32'hEEEE0000 || data_out_ready !== 1'b1) begin failures++; $display("FAIL rst_wb refill data: got %h/%b want eeee0000/1", data_out, data_out_ready); end
    endtask

    task automatic test_write_miss();
        @(negedge clk);
        address = 32'h0000_0024; data_in = 32'hCAFE0000; write_enable = 4'b1100; #1;
        asserts++; if (busy !== 1'b1) begin failures++; $display("FAIL write_miss busy: got %b want 1", busy); end
        wait_cmd("write_miss");
        do_fill("write_miss", 10'd4, 64'h99998888_77776666, 64'h0000BEEF_0000DEAD,
                64'h0, 64'h0);
        asserts++; if (busy !== 1'b0 || data_out_ready !== 1'b0) begin failures++; $display("FAIL write_miss applied: busy=%b ready=%b want 0/0", busy, data_out_ready); end
        @(negedge clk);
        write_enable = 4'b0000; data_in = 32'h0; #1;
        asserts++; if (data_out !== 32'hCAFE8888) begin failures++; $display("FAIL write_miss merged: got %h want cafe8888", data_out); end
        address = 32'h0000_0020; #1;
        asserts++; if (data_out !== 32'h77776666) begin failures++; $display("FAIL write_miss neighbour: got %h want 77776666", data_out); end
        @(negedge clk);
        enable = 1'b0; #1;
        asserts++; if (busy !== 1'b0 || data_out_ready !== 1'b0) begin failures++; $display("FAIL idle_disabled: busy=%b ready=%b want 0/0", busy, data_out_ready); end
    endtask

    initial begin
        test_reset();
        test_read_miss();
        test_write_hit();
        test_clean_miss();
        test_back_to_back();
        test_dirty_evict();
        test_clean_valid_miss();
        test_reset_mid_wb();
        test_write_miss();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
